// File: rtl/dmx_6_32_buf.sv
// dmx_6_32_buf: routes one tagged result word to one of six
// buffered consumer channels, each with its own valid/ready.
module dmx_6_32_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic [5:0]       out_valid,
  input  logic [5:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [WIDTH-1:0] out_data4,
  output logic [WIDTH-1:0] out_data5,
  output logic             bad_op,
  input  logic             clr,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [5:0]            valid_q, valid_d;
  logic [5:0][WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  bad_q, bad_d;

  logic       op_bad;
  logic [2:0] ch;
  logic [5:0] sel;
  logic [5:0] load;
  logic [5:0] drain;
  logic       acc;
  logic [2:0] pop;

  // codes 110/111 fall back to channel 5, like the 6:1 selector
  always_comb begin
    op_bad = in_op[2] & in_op[1];
    ch     = op_bad ? 3'd5 : in_op;
    sel    = 6'd1 << ch;
  end

  assign in_ready = |(sel & (~valid_q | out_ready));
  assign acc      = in_valid & in_ready;
  assign load     = sel & {6{acc}};
  assign drain    = valid_q & out_ready;

  // channel fill/drain, delivery count and sticky bad-op flag
  always_comb begin
    valid_d = (valid_q & ~drain) | load;
    data_d  = data_q;
    for (int k = 0; k < 6; k++) begin
      if (load[k]) data_d[k] = in_data;
    end
    pop = '0;
    for (int k = 0; k < 6; k++) begin
      pop = pop + {2'b00, drain[k]};
    end
    cnt_d = clr ? '0 : cnt_q + CNT_W'(pop);
    bad_d = clr ? 1'b0 : (bad_q | (acc & op_bad));
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign out_data4 = data_q[4];
  assign out_data5 = data_q[5];
  assign bad_op    = bad_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_dmx_6_32_buf.sv
// tb_dmx_6_32_buf: directed and random routing checks
// against a per-channel mailbox model.
module tb_dmx_6_32_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_data;
  logic [5:0]  out_valid;
  logic [5:0]  out_ready;
  logic [31:0] out_data0, out_data1, out_data2;
  logic [31:0] out_data3, out_data4, out_data5;
  logic        bad_op;
  logic        clr;
  logic [3:0]  xfer_cnt;

  dmx_6_32_buf #(.WIDTH(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .out_data4(out_data4), .out_data5(out_data5),
    .bad_op(bad_op), .clr(clr), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  bit          mv[6];
  logic [31:0] md[6];
  int          mcnt;
  bit          mbad;
  bit          last_acc;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 6; k++) begin
      mv[k] = 0;
      md[k] = '0;
    end
    mcnt = 0;
    mbad = 0;
  endtask

  function automatic logic [31:0] dout(int k);
    case (k)
      0: return out_data0;
      1: return out_data1;
      2: return out_data2;
      3: return out_data3;
      4: return out_data4;
      default: return out_data5;
    endcase
  endfunction

  task automatic check_outs(string tag);
    logic [5:0] ev;
    for (int k = 0; k < 6; k++) ev[k] = mv[k];
    chk({tag, "_valid"}, out_valid, ev);
    for (int k = 0; k < 6; k++)
      chk($sformatf("%s_data%0d", tag, k), dout(k), md[k]);
    chk({tag, "_bad"}, bad_op, mbad);
    chk({tag, "_cnt"}, xfer_cnt, mcnt % 16);
  endtask

  // one clock: check in_ready, advance the model, check registers
  task automatic cyc(string tag);
    int  ech;
    bit  erdy;
    #2;
    ech  = (in_op > 3'd5) ? 5 : int'(in_op);
    erdy = !mv[ech] || out_ready[ech];
    chk({tag, "_in_ready"}, in_ready, erdy);
    last_acc = in_valid && erdy;
    for (int k = 0; k < 6; k++) begin
      if (mv[k] && out_ready[k]) begin
        mcnt++;
        mv[k] = 0;
      end
    end
    if (last_acc) begin
      mv[ech] = 1;
      md[ech] = in_data;
      if (in_op > 3'd5) mbad = 1;
    end
    if (clr) begin
      mcnt = 0;
      mbad = 0;
    end
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  task automatic drive(bit v, logic [2:0] op, logic [31:0] d);
    in_valid = v;
    in_op    = op;
    in_data  = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_data   = '0;
    out_ready = '0;
    clr       = 1'b0;
    model_reset();
    #2;
    check_outs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single word through channel 2
    out_ready = 6'h3F;
    drive(1, 3'b010, 32'hDEADBEEF);
    cyc("t1_load");
    chk("t1_v", out_valid, 6'b000100);
    chk("t1_d2", out_data2, 32'hDEADBEEF);
    drive(0, 3'b000, '0);
    cyc("t1_drain");
    chk("t1_v0", out_valid, 6'b000000);
    chk("t1_c", xfer_cnt, 4'd1);

    // stall on channel 3, then drain and refill together
    out_ready = 6'b110111;
    drive(1, 3'b011, 32'h11);
    cyc("t2_first");
    drive(1, 3'b011, 32'h22);
    cyc("t2_block");
    chk("t2_rdy", in_ready, 1'b0);
    chk("t2_hold", out_data3, 32'h11);
    out_ready = 6'h3F;
    cyc("t2_swap");
    chk("t2_v3", out_valid[3], 1'b1);
    chk("t2_d3", out_data3, 32'h22);
    drive(0, 3'b000, '0);
    cyc("t2_empty");

    // stalled channel 0 must not block channel 4
    out_ready = 6'b111110;
    drive(1, 3'b000, 32'h55);
    cyc("t3_fill0");
    drive(1, 3'b100, 32'hA5);
    cyc("t3_ch4");
    chk("t3_v", out_valid, 6'b010001);
    drive(0, 3'b000, '0);
    out_ready = 6'h3F;
    cyc("t3_drain");

    // bad op lands on channel 5, clr wipes flag and count
    drive(1, 3'b111, 32'h7);
    cyc("t4_bad");
    chk("t4_flag", bad_op, 1'b1);
    chk("t4_d5", out_data5, 32'h7);
    drive(0, 3'b000, '0);
    clr = 1'b1;
    cyc("t4_clr");
    clr = 1'b0;
    chk("t4_flag0", bad_op, 1'b0);
    chk("t4_c0", xfer_cnt, 4'd0);

    // counter wrap: 15 deliveries, then two in one cycle
    out_ready = 6'b000001;
    for (int i = 0; i < 15; i++) begin
      drive(1, 3'b000, 32'h100 + i);
      cyc("t5_fill");
    end
    drive(1, 3'b001, 32'hB1);
    cyc("t5_ch1");
    drive(1, 3'b010, 32'hB2);
    cyc("t5_ch2");
    chk("t5_c15", xfer_cnt, 4'd15);
    drive(0, 3'b000, '0);
    out_ready = 6'b000110;
    cyc("t5_wrap");
    chk("t5_c1", xfer_cnt, 4'd1);

    // async reset mid-cycle with channels 1 and 5 full
    out_ready = 6'b000000;
    drive(1, 3'b001, 32'hC1);
    cyc("t6_f1");
    drive(1, 3'b101, 32'hC5);
    cyc("t6_f5");
    drive(0, 3'b000, '0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_v", out_valid, 6'b000000);
    chk("t6_d1", out_data1, 32'h0);
    chk("t6_d5", out_data5, 32'h0);
    check_outs("t6_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // random traffic; source holds op/data until accepted
    last_acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !last_acc)) begin
        drive(($urandom % 4) != 0, 3'($urandom % 8), $urandom);
      end
      out_ready = 6'($urandom);
      clr       = ($urandom % 25) == 0;
      cyc("rnd");
    end
    clr = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmx_6_32_buf.md
Name: dmx_6_32_buf

Overview:
- Distribution counterpart of the datapath 6:1 result selector: takes one 32-bit result stream tagged with a 3-bit destination code and delivers it to one of six consumer channels.
- Each channel has a one-entry output register with valid/ready handshake, so a stalled consumer blocks only traffic addressed to it.
- Sits between the execute-stage result bus and the writeback/forwarding consumers.

Parameters:
- WIDTH, 32, data width of input and every output channel
- CNT_W, 16, width of the delivered-transfer counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  input word accepted this cycle when high with in_valid
- in_op  input  3  destination code: 000..101 select channel 0..5
- in_data  input  WIDTH  word to route
- out_valid  output  6  bit k: channel k register holds a word
- out_ready  input  6  bit k: consumer k takes the word this cycle
- out_data0..out_data5  output  WIDTH each  channel k register contents
- bad_op  output  1  sticky flag: a word with in_op of 110 or 111 was accepted
- clr  input  1  synchronous clear of bad_op and xfer_cnt
- xfer_cnt  output  CNT_W  count of words delivered on any channel (handshakes completed on outputs), wraps

Behaviour:
- Reset (rst_n low, any time, asynchronous): out_valid = 0, all out_data = 0, bad_op = 0, xfer_cnt = 0. Reset mid-transfer discards held words; no partial state survives.
- Destination decode: ch = in_op for 000..101; 110 and 111 both map to channel 5 (same default as the 6:1 selector) and set bad_op on acceptance.
- in_ready = !out_valid[ch] || out_ready[ch]; this is combinational from in_op, out_valid and out_ready. in_ready does not depend on in_valid.
- Accept when in_valid && in_ready. The word is registered into channel ch at that edge, and out_valid[ch] = 1 from the next cycle. Latency is 1 cycle, and throughput is 1 word/cycle per channel.
- Channel k drain: when out_valid[k] && out_ready[k], out_valid[k] clears next cycle unless a new word for k is accepted the same cycle.
- Simultaneous drain and fill of the same channel: the register loads the new word and out_valid[k] stays 1 with no bubble.
- Channels are independent. One input word per cycle goes to exactly one channel. Other channels may drain in the same cycle.
- out_data[k] holds its value while out_valid[k] = 1 and out_ready[k] = 0. Data is unchanged after drain until the next load.
- in_valid high with in_ready low: nothing changes. The source must hold in_op and in_data stable until accepted.
- xfer_cnt increments by the popcount of (out_valid & out_ready) each cycle, 0..6. It wraps modulo 2^CNT_W.
- clr has priority over the same-cycle increment: xfer_cnt = 0 and bad_op = 0. If a bad op is accepted in the same cycle as clr, bad_op = 0 (clr wins).
- bad_op stays 1 until clr or reset.

Test Plan:
- Reset, then send in_op=010, in_data=32'hDEADBEEF with all out_ready=1 -> out_valid=6'b000100 one cycle later, out_data2=DEADBEEF, then out_valid=0; xfer_cnt=1.
- Stall: out_ready[3]=0; send two words to op 011 (0x11, 0x22) -> first held, in_ready=0 for second. Raise out_ready[3] -> 0x11 drains, 0x22 loaded the same cycle, out_valid[3] stays 1.
- Independence: channel 0 stalled and full; send 0xA5 to op 100 -> accepted immediately, out_valid[4]=1 next cycle while out_valid[0] remains 1.
- Bad op: send op 111, data 0x7 -> routed to channel 5, bad_op=1. Pulse clr -> bad_op=0, xfer_cnt=0.
- Counter: CNT_W=4, preload 15 deliveries, then drain 2 channels in one cycle -> xfer_cnt goes 15 -> 1.
- Async reset asserted mid-cycle with channels 1 and 5 full -> out_valid=0 and out_data=0 immediately, without waiting for a clock edge.
